// File: rtl/blob_counter_param.sv
// blob_counter_param: single-pass connected-component labeller that counts blobs above a fraction of the largest
module blob_counter_param #(
    parameter int IMG_W      = 800,
    parameter int IMG_H      = 600,
    parameter int N_LABELS   = 128,
    parameter int AREA_SHIFT = 3,
    localparam int LW = $clog2(N_LABELS),
    localparam int AW = $clog2(IMG_W * IMG_H + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_sof,
    input  logic          i_valid,
    input  logic          i_pix,
    input  logic          i_conn8,
    output logic          o_busy,
    output logic          o_done,
    output logic [7:0]    o_count,
    output logic [AW-1:0] o_max_area,
    output logic          o_overflow
);
    localparam int XW    = $clog2(IMG_W);
    localparam int TOTAL = IMG_W * IMG_H;

    typedef enum logic [2:0] {IDLE, PROC, RESOLVE, FINDMAX, COUNT, DONE} state_t;
    state_t state, state_nxt;

    logic [LW-1:0] line   [IMG_W];
    logic [LW-1:0] parent [N_LABELS];
    logic [AW-1:0] area   [N_LABELS];
    logic [LW:0]   next_label, nl;
    logic [LW-1:0] wlab, nwlab, idx;
    logic [XW-1:0] x, cx;
    logic [AW-1:0] pcnt, max_area, thr;
    logic [7:0]    nblobs;
    logic          conn8, row0, overflow;
    logic          accept_sof, accept_px, proc, last, first, at_end, conn;
    logic [LW-1:0] nb_n, nb_w, nb_nw, nb_ne, nb_x, lab, ma, mb, ra, rb, rp;
    logic          new_lab, ovf, do_merge, res_go;

    assign accept_sof = i_valid && i_sof && (state == IDLE || state == PROC || state == DONE);
    assign accept_px  = i_valid && !i_sof && state == PROC;
    assign proc       = accept_sof || accept_px;
    assign last       = accept_px && pcnt == AW'(TOTAL - 1);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next state: SOF always restarts, then frame end and the three table sweeps
    always_comb begin
        state_nxt = state;
        if (accept_sof)                        state_nxt = PROC;
        else if (last)                         state_nxt = RESOLVE;
        else if (state == RESOLVE && idx == '0) state_nxt = FINDMAX;
        else if (state == FINDMAX && &idx)     state_nxt = COUNT;
        else if (state == COUNT && &idx)       state_nxt = DONE;
    end

    // Outputs decoded from state and result registers
    always_comb begin
        o_busy     = state == RESOLVE || state == FINDMAX || state == COUNT;
        o_done     = state == DONE;
        o_count    = nblobs;
        o_max_area = max_area;
        o_overflow = overflow;
    end

    // Neighbour fetch; an SOF pixel sees a freshly cleared frame at column 0 of row 0
    always_comb begin
        cx     = i_sof ? '0 : x;
        at_end = cx == XW'(IMG_W - 1);
        first  = i_sof || row0;
        conn   = i_sof ? i_conn8 : conn8;
        nl     = i_sof ? (LW+1)'(1) : next_label;
        nb_n   = first ? '0 : line[cx];
        nb_w   = cx == '0 ? '0 : wlab;
        nb_nw  = (first || cx == '0) ? '0 : nwlab;
        nb_ne  = (first || at_end) ? '0 : line[at_end ? cx : cx + 1'b1];
        nb_x   = nb_w != '0 ? nb_w : nb_nw;
    end

    // Label choice with at most one merge request per pixel
    always_comb begin
        lab      = '0;
        new_lab  = 1'b0;
        ovf      = 1'b0;
        do_merge = 1'b0;
        ma       = '0;
        mb       = '0;
        if (i_pix) begin
            if (nb_n != '0) begin
                lab = nb_n;
                if (!conn && nb_w != '0 && nb_w != nb_n) begin
                    do_merge = 1'b1;
                    ma       = nb_n;
                    mb       = nb_w;
                end
            end else if (conn && nb_ne != '0) begin
                lab = nb_ne;
                if (nb_x != '0 && nb_x != nb_ne) begin
                    do_merge = 1'b1;
                    ma       = nb_ne;
                    mb       = nb_x;
                end
            end else if (conn && nb_nw != '0) lab = nb_nw;
            else if (nb_w != '0) lab = nb_w;
            else if (nl < (LW+1)'(N_LABELS)) begin
                lab     = nl[LW-1:0];
                new_lab = 1'b1;
            end else ovf = 1'b1;
        end
        ra     = parent[ma];
        rb     = parent[mb];
        rp     = parent[idx];
        thr    = max_area >> AREA_SHIFT;
        res_go = state == RESOLVE && idx != '0 && rp != idx && {1'b0, idx} < next_label;
    end

    // Line buffer, union table and per-label areas
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < N_LABELS; i++) begin
                parent[i] <= '0;
                area[i]   <= '0;
            end
            for (int i = 0; i < IMG_W; i++) line[i] <= '0;
            wlab  <= '0;
            nwlab <= '0;
        end else begin
            if (accept_sof) begin
                for (int i = 0; i < N_LABELS; i++) begin
                    parent[i] <= '0;
                    area[i]   <= '0;
                end
                for (int i = 0; i < IMG_W; i++) line[i] <= '0;
            end
            if (proc) begin
                line[cx] <= lab;
                wlab     <= lab;
                nwlab    <= i_sof ? '0 : line[cx];
                if (new_lab) begin
                    parent[lab] <= lab;
                    area[lab]   <= AW'(1);
                end else if (lab != '0 && area[lab] != '1) area[lab] <= area[lab] + 1'b1;
                if (do_merge && ra != rb) parent[ra > rb ? ra : rb] <= ra > rb ? rb : ra;
            end
            if (res_go) begin
                area[rp]  <= area[rp] + area[idx];
                area[idx] <= '0;
            end
        end
    end

    // Raster position, label allocator and the resolve/findmax/count sweep
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            conn8      <= 1'b0;
            x          <= '0;
            row0       <= 1'b0;
            pcnt       <= '0;
            next_label <= '0;
            overflow   <= 1'b0;
            idx        <= '0;
            nblobs     <= '0;
            max_area   <= '0;
        end else begin
            if (proc) begin
                x          <= at_end ? '0 : cx + 1'b1;
                row0       <= first && !at_end;
                pcnt       <= i_sof ? AW'(1) : pcnt + 1'b1;
                next_label <= nl + (LW+1)'(new_lab);
                overflow   <= (overflow && !i_sof) || ovf;
            end
            if (accept_sof) begin
                conn8    <= i_conn8;
                nblobs   <= '0;
                max_area <= '0;
            end
            if (last) idx <= LW'(N_LABELS - 1);
            else if (state == RESOLVE) idx <= idx == '0 ? LW'(1) : idx - 1'b1;
            else if (state == FINDMAX) begin
                idx <= &idx ? LW'(1) : idx + 1'b1;
                if (area[idx] > max_area) max_area <= area[idx];
            end else if (state == COUNT) begin
                idx <= idx + 1'b1;
                if (area[idx] > thr && area[idx] != '0 && nblobs != 8'hFF) nblobs <= nblobs + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_blob_counter_param.sv
// tb_blob_counter_param: directed frame vectors on an 8x4 image with 16-label and 4-label instances
module tb_blob_counter_param;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int AW = 6;

    typedef struct {
        logic [31:0] img;
        logic        c8;
        int          cnt;
        int          mx;
        int          ov;
    } vec_t;

    logic          clk = 1'b0, rst_n = 1'b0, sof = 1'b0, valid = 1'b0, pix = 1'b0, conn8 = 1'b0;
    logic          busy, done, ovf, busy_s, done_s, ovf_s;
    logic [7:0]    count, count_s;
    logic [AW-1:0] max_area, max_s;
    int            n_checks = 0;
    int            n_fail   = 0;
    int            k;
    vec_t          vecs [15];

    always #5 clk = ~clk;

    blob_counter_param #(.IMG_W(W), .IMG_H(H), .N_LABELS(16), .AREA_SHIFT(3)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof), .i_valid(valid), .i_pix(pix), .i_conn8(conn8),
        .o_busy(busy), .o_done(done), .o_count(count), .o_max_area(max_area), .o_overflow(ovf)
    );

    blob_counter_param #(.IMG_W(W), .IMG_H(H), .N_LABELS(4), .AREA_SHIFT(3)) dut_s (
        .i_clk(clk), .i_rst_n(rst_n), .i_sof(sof), .i_valid(valid), .i_pix(pix), .i_conn8(conn8),
        .o_busy(busy_s), .o_done(done_s), .o_count(count_s), .o_max_area(max_s), .o_overflow(ovf_s)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic send_range(input logic [31:0] img, input logic c8, input int first, input int last);
        for (int p = first; p <= last; p++) begin
            valid = 1'b1;
            sof   = (p == 0);
            pix   = img[p];
            conn8 = c8;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        sof   = 1'b0;
        pix   = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int c = 1; c <= 300; c++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        vecs[0]  = '{32'h0000_6363, 1'b0,  2,  4, 0};
        vecs[1]  = '{32'h0000_0705, 1'b0,  1,  5, 0};
        vecs[2]  = '{32'h0000_0201, 1'b0,  2,  1, 0};
        vecs[3]  = '{32'h0000_0201, 1'b1,  1,  2, 0};
        vecs[4]  = '{32'h0000_0102, 1'b1,  1,  2, 0};
        vecs[5]  = '{32'h0000_0102, 1'b0,  2,  1, 0};
        vecs[6]  = '{32'h0F0F_0FCF, 1'b0,  1, 16, 0};
        vecs[7]  = '{32'h0F0F_0FEF, 1'b0,  2, 16, 0};
        vecs[8]  = '{32'h0000_0000, 1'b0,  0,  0, 0};
        vecs[9]  = '{32'hFFFF_FFFF, 1'b1,  1, 32, 0};
        vecs[10] = '{32'hAA55_AA55, 1'b1,  1, 16, 0};
        vecs[11] = '{32'hAA55_AA55, 1'b0, 15,  1, 1};
        vecs[12] = '{32'h0000_0180, 1'b0,  2,  1, 0};
        vecs[13] = '{32'h0000_8001, 1'b1,  2,  1, 0};
        vecs[14] = '{32'h0001_0055, 1'b0,  5,  1, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_count", count, 0);
        check("idle_max", max_area, 0);
        check("idle_ovf", ovf, 0);

        send_range(32'hFFFF_FFFF, 1'b0, 1, 31);
        repeat (5) @(posedge clk);
        #1;
        check("idle_drop_busy", busy, 0);
        check("idle_drop_done", done, 0);

        for (int i = 0; i < 15; i++) begin
            send_range(vecs[i].img, vecs[i].c8, 0, W * H - 1);
            check($sformatf("v%0d_busy", i), busy, 1);
            wait_done(k);
            check($sformatf("v%0d_latency", i), k, 46);
            check($sformatf("v%0d_count", i), count, vecs[i].cnt);
            check($sformatf("v%0d_max", i), max_area, vecs[i].mx);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].ov);
        end
        check("small_done", done_s, 1);
        check("small_count", count_s, 3);
        check("small_max", max_s, 1);
        check("small_ovf", ovf_s, 1);

        send_range(32'hFFFF_FFFF, 1'b0, 0, 0);
        check("sof_clr_done", done, 0);
        check("sof_clr_count", count, 0);
        check("sof_clr_max", max_area, 0);
        send_range(32'hFFFF_FFFF, 1'b0, 1, 9);
        send_range(32'h000C_0C00, 1'b0, 0, 31);
        wait_done(k);
        check("abort_latency", k, 46);
        check("abort_count", count, 1);
        check("abort_max", max_area, 4);

        send_range(32'hFFFF_FFFF, 1'b0, 0, 30);
        send_range(32'h0000_0001, 1'b0, 0, 0);
        check("sof_last_busy", busy, 0);
        send_range(32'h0000_0001, 1'b0, 1, 31);
        wait_done(k);
        check("sof_last_latency", k, 46);
        check("sof_last_count", count, 1);
        check("sof_last_max", max_area, 1);

        send_range(32'h000C_0C00, 1'b0, 0, 31);
        valid = 1'b1;
        sof   = 1'b1;
        pix   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        valid = 1'b0;
        sof   = 1'b0;
        pix   = 1'b0;
        wait_done(k);
        check("busy_drop_latency", k, 43);
        check("busy_drop_count", count, 1);
        check("busy_drop_max", max_area, 4);

        send_range(32'hAA55_AA55, 1'b0, 0, 31);
        repeat (5) @(posedge clk);
        #1;
        check("mid_resolve_busy", busy, 1);
        check("mid_resolve_ovf", ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ovf", ovf, 0);
        check("arst_count", count, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_done(k);
        check("arst_no_result", k, -1);
        send_range(32'h000C_0C00, 1'b0, 0, 31);
        wait_done(k);
        check("post_rst_latency", k, 46);
        check("post_rst_count", count, 1);
        check("post_rst_max", max_area, 4);
        check("post_rst_ovf", ovf, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/blob_counter_param.md
# blob_counter_param

Parametrised streaming connected-component counter for binary camera frames. It sits after the binarisation stage of the camera pipeline. It labels foreground pixels in a single raster pass using a one-row label line buffer and an equivalence table, then resolves the table. It reports how many blobs have an area above a fraction of the largest blob, plus the largest area and a label-overflow flag. It generalises the fixed 800x600, 4-neighbour counter with runtime 4/8 connectivity, configurable geometry, label depth and threshold, frame restart, and overflow reporting.

## Interface
- IMG_W, 800, pixels per row (≥2)
- IMG_H, 600, rows per frame (≥1)
- N_LABELS, 128, label table depth including background label 0 (power of 2, ≥4)
- AREA_SHIFT, 3, count threshold is max_area >> AREA_SHIFT
- Derived: LW = clog2(N_LABELS); AW = clog2(IMG_W*IMG_H+1)
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_sof  in  1  start of frame, qualified by i_valid; that pixel is pixel 0
- i_valid  in  1  pixel valid
- i_pix  in  1  1 = foreground
- i_conn8  in  1  0 = 4-connectivity, 1 = 8-connectivity; sampled on the SOF pixel
- o_busy  out  1  high in RESOLVE/FINDMAX/COUNT; pixels are ignored while high
- o_done  out  1  result valid; held until next accepted SOF
- o_count  out  8  blobs with area > threshold, saturating at 255
- o_max_area  out  AW  largest resolved blob area
- o_overflow  out  1  new label required while table full in this frame

## Operation
- States: IDLE, PROC, RESOLVE, FINDMAX, COUNT, DONE.
- **SOF handling.** An SOF pixel is accepted in IDLE, PROC or DONE.
  - It clears the line buffer, parent[], area[], next_label = 1, pixel counter, overflow, count, max_area and done.
  - It latches conn8, processes the pixel, and enters PROC.
  - SOF in PROC aborts the current frame without output.
- **Pixel acceptance.** In PROC, each i_valid pixel is processed in its cycle. Non-SOF pixels in IDLE/DONE and all pixels while busy are dropped.
- **Neighbours.** W = previous label in the row; N, NW, NE come from the line buffer.
  - Out-of-image neighbours read 0: row 0 has no N/NW/NE, column 0 has no W/NW, and column IMG_W-1 has no NE.
- **Label selection, background pixel.** If i_pix = 0, the label is 0.
- **Label selection, 4-connectivity.**
  - If N≠0, use N; if W≠0 also and W≠N, merge(N, W).
  - Else if W≠0, use W.
  - Else take a new label.
- **Label selection, 8-connectivity.**
  - If N≠0, use N.
  - Else if NE≠0, use NE, and merge(NE, X) where X = W if W≠0, else NW, when X≠0 and X≠NE.
  - Else if NW≠0, use NW; else if W≠0, use W.
  - Else take a new label.
- **New label.** If next_label < N_LABELS: assign it, set parent = self and area = 1, then increment next_label.
  - Otherwise the label is 0 (pixel treated as background) and o_overflow is set.
- **Area.** Every labelled pixel does area[label]++, saturating at 2^AW−1.
- **merge(a, b).** ra = parent[a], rb = parent[b]; if ra≠rb, parent[max(ra,rb)] ← min(ra,rb).
  - Invariant: parent[i] ≤ i.
  - At most one merge per pixel, resolved combinationally the same cycle.
- **End of frame.** After pixel IMG_W*IMG_H−1 is accepted, go to RESOLVE.
- **RESOLVE.** i = N_LABELS−1 down to 1, one per cycle: if parent[i]≠i and i<next_label, then area[parent[i]] += area[i] and area[i] = 0.
- **FINDMAX.** i = 1..N_LABELS−1: max_area = max(max_area, area[i]).
- **COUNT.** i = 1..N_LABELS−1: if area[i] > (max_area >> AREA_SHIFT) and area[i]≠0, count++ (saturating).
- **DONE.** o_done = 1, outputs stable.

## Timing
- Reset values: all outputs 0, state IDLE, tables 0.
- Throughput: one pixel per cycle in PROC, no stall required.
- Latency: o_busy rises the cycle after the last pixel edge. o_done rises 3*(N_LABELS−1)+1 cycles after that edge, the same cycle o_busy falls. o_count, o_max_area and o_overflow are valid whenever o_done = 1.
- o_done and results clear the cycle after an SOF is accepted in DONE.
- Asynchronous reset at any point (mid-PROC, mid-RESOLVE) returns to IDLE with outputs 0. No partial result is produced.
- Simultaneous SOF with the last pixel of a frame: SOF wins, and the frame restarts.

## Test plan
- IMG_W=8, IMG_H=4, N_LABELS=16, 4-conn; two disjoint 2x2 squares at columns 0–1 and 5–6 -> o_count=2, o_max_area=4, o_overflow=0, o_done 46 cycles after last pixel.
- Same params; U shape: row0 "10100000", row1 "11100000" -> merge occurs; o_count=1, o_max_area=5.
- Diagonal pixels (0,0), (1,1): conn8=0 -> o_count=2, o_max_area=1; repeat with conn8=1 -> o_count=1, o_max_area=2. Also NE case (0,1),(1,0) with conn8=1 -> o_count=1.
- N_LABELS=4; five isolated dots in row 0 at columns 0, 2, 4, 6 and row 2 column 0 -> o_overflow=1, o_count=3, o_max_area=1.
- AREA_SHIFT=3; blobs of area 16 and 2 -> threshold 2, o_count=1; change small blob to area 3 -> o_count=2.
- SOF mid-frame after 10 pixels, then full frame of one 2x2 square -> only second frame reported (o_count=1). Reset asserted mid-RESOLVE -> all outputs 0, IDLE; next full frame gives correct result.
